// File: rtl/whack_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : whack_game_ctrl
// Purpose  : Round sequencer for a whack-a-mole game. Runs the IDLE/RUN/OVER
//            state machine, owns the per-second round countdown, moves the lit
//            mole using an 8-bit LFSR, detects button hits and misses, and
//            keeps a saturating score.
// Ports    : clk        - system clock
//            reset      - synchronous, active-high reset
//            start      - start request, level or pulse
//            btn[3:0]   - debounced, synchronised player buttons
//            mole[3:0]  - one-hot lit mole, zero outside RUN
//            time_left  - seconds remaining in the round
//            score      - current score, saturating 0..255
//            playing    - high while in RUN
//            game_over  - high while in OVER
// Revision : 1.0 - initial release
// ============================================================================
module whack_game_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned MOLE_DIV  = 75_000_000,
    parameter int unsigned ROUND_SEC = 20,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] mole,
    output logic [7:0] time_left,
    output logic [7:0] score,
    output logic       playing,
    output logic       game_over
);

    // Counter widths are guarded so a divider of 1 still yields a 1-bit counter.
    localparam int unsigned c_sec_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned c_mole_w = (MOLE_DIV > 1) ? $clog2(MOLE_DIV) : 1;

    localparam logic [c_sec_w-1:0]  c_sec_last  = c_sec_w'(TICK_DIV - 1);
    localparam logic [c_mole_w-1:0] c_mole_last = c_mole_w'(MOLE_DIV - 1);
    localparam logic [7:0]          c_round     = 8'(ROUND_SEC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [7:0]           r_lfsr;
    logic [3:0]           r_btn_q;
    logic [c_sec_w-1:0]   r_sec_cnt;
    logic [c_mole_w-1:0]  r_mole_cnt;
    logic [3:0]           r_mole;
    logic [1:0]           r_mole_idx;
    logic [7:0]           r_time_left;
    logic [7:0]           r_score;
    logic                 r_playing;
    logic                 r_game_over;

    logic [7:0]           w_lfsr_next;
    logic [c_sec_w-1:0]   w_sec_cnt_next;
    logic [c_mole_w-1:0]  w_mole_cnt_next;
    logic [3:0]           w_mole_next;
    logic [1:0]           w_mole_idx_next;
    logic [7:0]           w_time_left_next;
    logic [7:0]           w_score_next;

    logic [3:0]           w_rise;
    logic                 w_run;
    logic                 w_start_load;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_sec_tick;
    logic                 w_last_tick;
    logic                 w_mole_wrap;
    logic [1:0]           w_pick_raw;
    logic [1:0]           w_pick_idx;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    assign w_rise       = btn & ~r_btn_q;
    assign w_run        = (r_state == S_RUN);
    assign w_start_load = start && ((r_state == S_IDLE) || (r_state == S_OVER));

    // A hit wins over any simultaneous wrong-button rise.
    assign w_hit  = w_run && (|(w_rise & r_mole));
    assign w_miss = w_run && (|w_rise) && !w_hit;

    assign w_sec_tick  = w_run && (r_sec_cnt == c_sec_last);
    assign w_last_tick = w_sec_tick && (r_time_left <= 8'd1);
    assign w_mole_wrap = w_run && (r_mole_cnt == c_mole_last);

    // Step past the current mole so the same one is never chosen twice in a
    // row. When nothing is lit (first pick of a round) the raw index is used.
    assign w_pick_raw = r_lfsr[1:0];
    assign w_pick_idx = ((r_mole != 4'd0) && (w_pick_raw == r_mole_idx)) ?
                        (w_pick_raw + 2'd1) : w_pick_raw;

    // ------------------------------------------------------------------------
    // State machine: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_state_next = S_RUN;
            S_RUN:   if (w_last_tick) w_state_next = S_OVER;
            S_OVER:  if (start)       w_state_next = S_RUN;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: countdown, mole selection and score
    // ------------------------------------------------------------------------
    always_comb begin
        w_sec_cnt_next   = r_sec_cnt;
        w_mole_cnt_next  = r_mole_cnt;
        w_mole_next      = r_mole;
        w_mole_idx_next  = r_mole_idx;
        w_time_left_next = r_time_left;
        w_score_next     = r_score;

        if (w_start_load) begin
            w_sec_cnt_next   = '0;
            w_mole_cnt_next  = '0;
            w_time_left_next = c_round;
            w_score_next     = 8'd0;
            w_mole_idx_next  = w_pick_idx;
            w_mole_next      = 4'b0001 << w_pick_idx;
        end else if (w_run) begin
            if (w_hit && (r_score != 8'hFF)) begin
                w_score_next = r_score + 8'd1;
            end else if (w_miss && (r_score != 8'd0)) begin
                w_score_next = r_score - 8'd1;
            end

            w_sec_cnt_next = w_sec_tick ? '0 : (r_sec_cnt + 1'b1);

            if (w_sec_tick && (r_time_left != 8'd0)) begin
                w_time_left_next = r_time_left - 8'd1;
            end

            // Leaving RUN blanks the mole; otherwise a hit and a wrap landing
            // on the same edge still produce exactly one new mole.
            if (w_last_tick) begin
                w_mole_next = 4'd0;
            end else if (w_hit || w_mole_wrap) begin
                w_mole_idx_next = w_pick_idx;
                w_mole_next     = 4'b0001 << w_pick_idx;
            end

            w_mole_cnt_next = (w_hit || w_mole_wrap) ? '0 : (r_mole_cnt + 1'b1);
        end else if (r_state == S_OVER) begin
            w_mole_next = 4'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_btn_q     <= 4'd0;
            r_sec_cnt   <= '0;
            r_mole_cnt  <= '0;
            r_mole      <= 4'd0;
            r_mole_idx  <= 2'd0;
            r_time_left <= c_round;
            r_score     <= 8'd0;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_btn_q     <= btn;
            r_sec_cnt   <= w_sec_cnt_next;
            r_mole_cnt  <= w_mole_cnt_next;
            r_mole      <= w_mole_next;
            r_mole_idx  <= w_mole_idx_next;
            r_time_left <= w_time_left_next;
            r_score     <= w_score_next;
            r_playing   <= (w_state_next == S_RUN);
            r_game_over <= (w_state_next == S_OVER);
        end
    end

    assign mole      = r_mole;
    assign time_left = r_time_left;
    assign score     = r_score;
    assign playing   = r_playing;
    assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_whack_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_whack_game_ctrl
// Purpose  : Self-checking bench for whack_game_ctrl. A behavioural game model
//            (integer counters, mole index) predicts every output; directed
//            scenarios plus a randomized run compare the DUT against it. A
//            second instance with a long round covers score saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_whack_game_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int MOLE_DIV  = 25;
    localparam int ROUND_SEC = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] btn;
    logic [3:0] mole;
    logic [7:0] time_left;
    logic [7:0] score;
    logic       playing;
    logic       game_over;

    logic       start2;
    logic [3:0] btn2;
    logic [3:0] mole2;
    logic [7:0] time_left2;
    logic [7:0] score2;
    logic       playing2;
    logic       game_over2;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = over; m_idx = -1 means no mole.
    int         m_state;
    int         m_time;
    int         m_score;
    int         m_sec;
    int         m_mcnt;
    int         m_idx;
    logic [7:0] m_lfsr;
    logic [3:0] m_btnq;

    whack_game_ctrl #(
        .TICK_DIV (TICK_DIV),
        .MOLE_DIV (MOLE_DIV),
        .ROUND_SEC(ROUND_SEC),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .btn      (btn),
        .mole     (mole),
        .time_left(time_left),
        .score    (score),
        .playing  (playing),
        .game_over(game_over)
    );

    whack_game_ctrl #(
        .TICK_DIV (10),
        .MOLE_DIV (25),
        .ROUND_SEC(40),
        .LFSR_SEED(8'hA5)
    ) u_sat (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .btn      (btn2),
        .mole     (mole2),
        .time_left(time_left2),
        .score    (score2),
        .playing  (playing2),
        .game_over(game_over2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int pick(input logic [7:0] l, input int cur);
        int i;
        i = int'(l % 8'd4);
        if (cur >= 0 && i == cur) i = (i + 1) % 4;
        return i;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_time  = ROUND_SEC;
        m_score = 0;
        m_sec   = 0;
        m_mcnt  = 0;
        m_idx   = -1;
        m_lfsr  = 8'hA5;
        m_btnq  = 4'd0;
    endtask

    task automatic model_edge(input logic s, input logic [3:0] b);
        logic [3:0] rise;
        bit hit, miss, tick, wrap;
        rise = b & ~m_btnq;
        if (m_state != 1) begin
            if (s) begin
                m_state = 1;
                m_time  = ROUND_SEC;
                m_score = 0;
                m_sec   = 0;
                m_mcnt  = 0;
                m_idx   = pick(m_lfsr, -1);
            end
        end else begin
            hit  = (m_idx >= 0) && rise[m_idx];
            miss = !hit && (rise != 4'd0);
            if (hit)       m_score = (m_score < 255) ? m_score + 1 : 255;
            else if (miss) m_score = (m_score > 0) ? m_score - 1 : 0;
            tick = (m_sec == TICK_DIV - 1);
            wrap = (m_mcnt == MOLE_DIV - 1);
            m_sec = tick ? 0 : m_sec + 1;
            if (tick && m_time > 0) m_time = m_time - 1;
            if (tick && m_time == 0) begin
                m_state = 2;
                m_idx   = -1;
            end else if (hit || wrap) begin
                m_idx = pick(m_lfsr, m_idx);
            end
            m_mcnt = (hit || wrap) ? 0 : m_mcnt + 1;
        end
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_btnq = b;
    endtask

    function automatic logic [3:0] exp_mole();
        return (m_idx < 0) ? 4'd0 : (4'd1 << m_idx);
    endfunction

    function automatic logic [21:0] exp_vec();
        return {exp_mole(), 8'(m_time), 8'(m_score), (m_state == 1), (m_state == 2)};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {mole, time_left, score, playing, game_over};
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus primitives
    // ------------------------------------------------------------------------
    task automatic step(input logic s, input logic [3:0] b);
        start = s;
        btn   = b;
        model_edge(s, b);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        start = 1'b0;
        btn   = 4'd0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [3:0] wrong_bit(input logic [3:0] lit);
        for (int i = 0; i < 4; i++) if (!lit[i]) return 4'd1 << i;
        return 4'd0;
    endfunction

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset(3);
        tests_run++; if (mole !== 4'd0) begin tests_failed++; $display("FAIL reset_mole: got %h want 0", mole); end
        tests_run++; if (score !== 8'd0) begin tests_failed++; $display("FAIL reset_score: got %0d want 0", score); end
        tests_run++; if (time_left !== 8'(ROUND_SEC)) begin tests_failed++; $display("FAIL reset_time: got %0d want %0d", time_left, ROUND_SEC); end
        tests_run++; if (playing !== 1'b0) begin tests_failed++; $display("FAIL reset_playing: got %b want 0", playing); end
        tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    endtask

    task automatic test_round_timeout();
        logic [3:0] prev;
        step(1'b1, 4'd0);
        tests_run++;
        if (playing !== 1'b1 || mole === 4'd0) begin
            tests_failed++; $display("FAIL start_latency: playing=%b mole=%h want playing=1 mole!=0", playing, mole);
        end
        prev = mole;
        for (int i = 1; i <= 32; i++) begin
            step(1'b0, 4'd0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++; $display("FAIL timeout_model c%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i < 30) begin
                tests_run++;
                if (time_left !== 8'(3 - i / 10)) begin
                    tests_failed++; $display("FAIL timeout_count c%0d: got %0d want %0d", i, time_left, 3 - i / 10);
                end
                tests_run++;
                if ((i == 25 && (mole === prev || mole === 4'd0)) || (i != 25 && mole !== prev)) begin
                    tests_failed++; $display("FAIL mole_move c%0d: got %h prev %h", i, mole, prev);
                end
                prev = mole;
            end else begin
                tests_run++;
                if (game_over !== 1'b1 || mole !== 4'd0 || time_left !== 8'd0 || playing !== 1'b0) begin
                    tests_failed++; $display("FAIL over_state c%0d: got go=%b mole=%h t=%0d pl=%b want 1,0,0,0", i, game_over, mole, time_left, playing);
                end
            end
        end
    endtask

    task automatic test_hit();
        logic [3:0] old_m, new_m;
        do_reset(1);
        step(1'b1, 4'd0);
        repeat (3) step(1'b0, 4'd0);
        old_m = mole;
        step(1'b0, old_m);
        new_m = mole;
        tests_run++;
        if (score !== 8'd1 || new_m === old_m || new_m === 4'd0) begin
            tests_failed++; $display("FAIL hit: score=%0d mole=%h old=%h want score 1, new nonzero mole", score, new_m, old_m);
        end
        // Held button gives no further rises; the new mole must last a full period.
        for (int j = 1; j <= 25; j++) begin
            step(1'b0, old_m);
            tests_run++;
            if ((j < 25 && mole !== new_m) || (j == 25 && (mole === new_m || mole === 4'd0)) || dut_vec() !== exp_vec()) begin
                tests_failed++; $display("FAIL hit_mole_cnt j%0d: got %h want %h", j, dut_vec(), exp_vec());
            end
            new_m = (j == 25) ? mole : new_m;
        end
    endtask

    task automatic test_miss();
        do_reset(1);
        step(1'b1, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, wrong_bit(mole));
        tests_run++;
        if (score !== 8'd0) begin tests_failed++; $display("FAIL miss_at_zero: got %0d want 0", score); end
        step(1'b0, 4'd0);
        step(1'b0, mole);
        tests_run++;
        if (score !== 8'd1) begin tests_failed++; $display("FAIL miss_setup_hit: got %0d want 1", score); end
        step(1'b0, 4'd0);
        step(1'b0, wrong_bit(mole));
        tests_run++;
        if (score !== 8'd0 || dut_vec() !== exp_vec()) begin
            tests_failed++; $display("FAIL miss_decrement: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_double_rise();
        do_reset(1);
        step(1'b1, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, mole | wrong_bit(mole));
        tests_run++;
        if (score !== 8'd1) begin tests_failed++; $display("FAIL double_rise: got %0d want 1", score); end
        step(1'b0, 4'd0);
        step(1'b0, 4'hF);
        tests_run++;
        if (score !== 8'd2 || dut_vec() !== exp_vec()) begin
            tests_failed++; $display("FAIL all_buttons: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_final_tick_hit();
        do_reset(1);
        step(1'b1, 4'd0);
        repeat (29) step(1'b0, 4'd0);
        step(1'b0, mole);
        tests_run++;
        if (score !== 8'd1 || game_over !== 1'b1 || mole !== 4'd0 || time_left !== 8'd0) begin
            tests_failed++; $display("FAIL final_tick_hit: score=%0d go=%b mole=%h t=%0d want 1,1,0,0", score, game_over, mole, time_left);
        end
        step(1'b0, 4'd0);
        step(1'b1, 4'd0);
        tests_run++;
        if (score !== 8'd0 || time_left !== 8'd3 || playing !== 1'b1 || game_over !== 1'b0 || mole === 4'd0) begin
            tests_failed++; $display("FAIL restart: score=%0d t=%0d pl=%b go=%b mole=%h want 0,3,1,0,lit", score, time_left, playing, game_over, mole);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        step(1'b1, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, mole);
        repeat (10) step(1'b0, 4'd0);
        step(1'b1, 4'd0);
        tests_run++;
        if (score !== 8'd1 || time_left !== 8'd2 || playing !== 1'b1 || dut_vec() !== exp_vec()) begin
            tests_failed++; $display("FAIL start_in_run: got %h want %h", dut_vec(), exp_vec());
        end
        do_reset(1);
        tests_run++;
        if (dut_vec() !== {4'd0, 8'd3, 8'd0, 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL reset_mid_round: got %h want %h", dut_vec(), {4'd0, 8'd3, 8'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] b;
        do_reset(1);
        for (int n = 0; n < 1200; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset(1);
            end else begin
                b = ($urandom_range(0, 1) == 1) ? exp_mole() : 4'd0;
                if ($urandom_range(0, 3) == 0) b = b | 4'($urandom);
                step(r < 6, b);
            end
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++; $display("FAIL random n%0d: got %h want %h", n, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        start2 = 1'b1;
        btn2   = 4'd0;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            btn2 = mole2;
            @(posedge clk); #1;
            if (k == 254 || k == 255 || k == 256 || k == 300) begin
                tests_run++;
                if (score2 !== 8'((k < 255) ? k : 255)) begin
                    tests_failed++; $display("FAIL saturate k%0d: got %0d want %0d", k, score2, (k < 255) ? k : 255);
                end
            end
        end
        btn2 = 4'd0;
        tests_run++;
        if (playing2 !== 1'b1) begin tests_failed++; $display("FAIL saturate_playing: got %b want 1", playing2); end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        btn    = 4'd0;
        start2 = 1'b0;
        btn2   = 4'd0;
        model_reset();
        test_reset();
        test_round_timeout();
        test_hit();
        test_miss();
        test_double_rise();
        test_final_tick_hit();
        test_reset_mid();
        test_random();
        do_reset(1);
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
